aes128_key_sched_ctrl: RTL and testbench
========================================

Name: aes128_key_sched_ctrl

Overview:
Iterative AES-128 key-schedule controller. It accepts a 128-bit cipher key through a valid/ready handshake and expands it into round keys 1..10, one round key per clock. It reuses a single round-key step instead of the fully unrolled 44-word combinational expansion. The 11 round keys are held in an internal buffer, and the cipher round sequencer reads them by index (forward order for encryption, reverse order for decryption).

Parameters:
NR, 10, number of rounds; fixed for AES-128; sizes the buffer (NR+1 entries) and the round counter.
KW, 128, key / round-key width in bits; big-endian bit order [0:KW-1], word 0 = bits [0:31].

Ports:
clk  in  1  system clock, rising edge.
rst_n  in  1  reset, asynchronous, active-low.
key_valid  in  1  key_in is valid.
key_ready  out  1  controller can accept a key; high in IDLE and READY.
key_in  in  [0:127]  cipher key.
rk_idx  in  4  round-key index to read, 0..10.
rk_out  out  [0:127]  registered round key for rk_idx.
rk_valid  out  1  all 11 round keys for the current key are valid.
busy  out  1  expansion in progress.
done  out  1  one-cycle pulse when expansion completes.

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- Reset values:
  - State IDLE, round counter 0, rcon 0x01.
  - All buffer entries 0, rk_out 0.
  - rk_valid 0, busy 0, done 0, key_ready 1.
- State IDLE:
  - key_ready=1.
  - On key_valid&&key_ready: buf[0]<=key_in, cur<=key_in, round<=1, rcon<=0x01, go to EXPAND.
- State EXPAND:
  - key_ready=0 and busy=1; key_valid is ignored.
  - Each cycle: nxt=step(cur,rcon); buf[round]<=nxt; cur<=nxt; round<=round+1; rcon<=xtime(rcon).
  - xtime: left shift, XOR 0x1b if the MSB was set. Sequence is 01,02,04,08,10,20,40,80,1b,36.
  - When round==10 is written, go to READY.
- State READY:
  - rk_valid=1, key_ready=1, busy=0.
  - done is high for exactly the one cycle after the buf[10] write.
  - A new handshake behaves as in IDLE: rk_valid drops the cycle after acceptance and the buffer is overwritten progressively.
- Step function: w0'=w0^SubWord(RotWord(w3))^{rcon,24'h0}; w1'=w1^w0'; w2'=w2^w1'; w3'=w3^w2'.
- Latency: acceptance edge E0; buf[k] is written at edge Ek; rk_valid and done are visible after E10, i.e. 10 cycles from acceptance to rk_valid.
- Read port:
  - rk_out<=buf[rk_idx] on every edge (1-cycle read latency), in any state.
  - rk_idx>10 gives rk_out=0.
  - During EXPAND, entries with index < round are already final; rk_valid only qualifies the full set.
- Simultaneous events: if the read and the write hit the same index in one cycle, rk_out returns the old contents (read-before-write).
- Reset mid-EXPAND: immediate return to IDLE, buffer cleared, no done pulse.
- Back-to-back keys: a key accepted in the same cycle done is high is legal; the next expansion starts with no idle cycle.

Decomposition:
- Package aes_pkg:
  - NR and KW constants, and the Rcon initial value 8'h01.
  - The S-box byte function and xtime function.
  - Typedef for the 128-bit round key and for the 4-bit round index.
- Sub-module aes_key_round (combinational, 4 S-box lookups): inputs prev key [0:127] and rcon[7:0]; output next key [0:127]. The controller instantiates exactly one.
- The controller holds the FSM, round counter, rcon register, buffer and read register.

Test Plan:
1. Reset, then check outputs: key_ready=1, rk_valid=0, busy=0, done=0, rk_out=0.
2. FIPS-197 key 2b7e151628aed2a6abf7158809cf4f3c:
   - done pulse exactly 10 cycles after acceptance.
   - rk_idx=1 gives a0fafe1788542cb123a339392a6c7605.
   - rk_idx=10 gives d014f9a8c9ee2589e13f0cc8b6630ca6.
   - rk_idx=0 echoes the key.
3. All-zero key:
   - rk[1]=62636363626363636263636362636363.
   - rk[10]=b4ef5bcb3e92e21123e951cf6f8f188e.
4. Handshake and second key:
   - key_valid asserted during EXPAND with a different key: ignored, results unchanged.
   - A second key offered in the done cycle is accepted; rk_valid drops next cycle; the new rk[10] is correct 10 cycles later.
5. Reset mid-operation: rst_n pulsed low at round 5 gives immediate IDLE, buffer reads 0, no done pulse; the following expansion is correct.
6. Read-port corners:
   - rk_idx=11..15 gives rk_out=0.
   - Sweeping rk_idx 10→0 after done returns the keys in reverse order with 1-cycle latency.

Source files
------------

// File: rtl/aes_pkg.sv
// AES-128 key-schedule shared definitions: sizes, types, GF(2^8) helpers.
// Latency: none; constants and pure combinational functions only.
// Backpressure: not applicable.
package aes_pkg;
   localparam int NR = 10;
   localparam int KW = 128;
   localparam logic [7:0] RCON_INIT = 8'h01;

   typedef logic [0:KW-1] rk_t;
   typedef logic [3:0]    rk_idx_t;

   localparam rk_idx_t LAST_ROUND = rk_idx_t'(NR);

   // Multiply by x in GF(2^8) modulo x^8+x^4+x^3+x+1.
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = '0;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // S-box as multiplicative inverse (b^254, so 0 maps to 0) followed by the affine map.
   function automatic logic [7:0] sbox(input logic [7:0] b);
      logic [7:0] inv;
      inv = b;
      for (int i = 0; i < 6; i++) inv = gf_mul(gf_mul(inv, inv), b);
      inv = gf_mul(inv, inv);
      return inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]}
                 ^ {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
   endfunction
endpackage

// File: rtl/aes_key_round.sv
// One AES-128 key-expansion step: next round key from previous key and rcon.
// Latency: purely combinational (four S-box evaluations on the rotated last word).
// Backpressure: none; the caller decides when to register the result.
module aes_key_round
   import aes_pkg::*;
(
   input  rk_t        prev,
   input  logic [7:0] rcon,
   output rk_t        next
);
   logic [31:0] w0, w1, w2, w3;
   logic [31:0] rot, sub;
   logic [31:0] n0, n1, n2, n3;

   // Word 0 is the leftmost 32 bits of the big-endian key.
   assign w0 = prev[0:31];
   assign w1 = prev[32:63];
   assign w2 = prev[64:95];
   assign w3 = prev[96:127];

   assign rot = {w3[23:0], w3[31:24]};
   assign sub = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])};

   assign n0 = w0 ^ sub ^ {rcon, 24'h0};
   assign n1 = w1 ^ n0;
   assign n2 = w2 ^ n1;
   assign n3 = w3 ^ n2;

   assign next = {n0, n1, n2, n3};
endmodule

// File: rtl/aes128_key_sched_ctrl.sv
// Iterative AES-128 key schedule: expands one round key per clock into an 11-entry buffer.
// Latency: 10 cycles from key acceptance to rk_valid/done; round-key reads are 1 cycle.
// Backpressure: key_ready low while expanding; keys offered then are ignored, not queued.
module aes128_key_sched_ctrl
   import aes_pkg::*;
(
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_valid,
   output logic          key_ready,
   input  logic [0:KW-1] key_in,
   input  logic [3:0]    rk_idx,
   output logic [0:KW-1] rk_out,
   output logic          rk_valid,
   output logic          busy,
   output logic          done
);
   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_EXPAND = 2'd1;
   localparam logic [1:0] ST_READY  = 2'd2;

   logic [1:0] state;
   rk_idx_t    round;
   logic [7:0] rcon;
   rk_t        cur;
   rk_t        nxt;
   rk_t        rk_buf [0:NR];
   logic       accept;

   assign key_ready = (state != ST_EXPAND);
   assign busy      = (state == ST_EXPAND);
   assign rk_valid  = (state == ST_READY);
   assign accept    = key_valid && key_ready;

   aes_key_round u_round (
      .prev (cur),
      .rcon (rcon),
      .next (nxt)
   );

   // Sequencing: accept a key, step once per cycle through rounds 1..NR, pulse done at the end.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         round <= '0;
         rcon  <= RCON_INIT;
         cur   <= '0;
         done  <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            ST_EXPAND: begin
               cur  <= nxt;
               rcon <= xtime(rcon);
               if (round == LAST_ROUND) begin
                  state <= ST_READY;
                  round <= '0;
                  done  <= 1'b1;
               end else begin
                  round <= round + 4'd1;
               end
            end
            default: begin
               // IDLE and READY both take a new key; READY falls back to expansion directly.
               if (accept) begin
                  state <= ST_EXPAND;
                  cur   <= key_in;
                  round <= 4'd1;
                  rcon  <= RCON_INIT;
               end
            end
         endcase
      end
   end

   // Round-key buffer: entry 0 on acceptance, entry `round` on each expansion step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i <= NR; i++) rk_buf[i] <= '0;
      end else if (accept) begin
         rk_buf[0] <= key_in;
      end else if (busy) begin
         rk_buf[round] <= nxt;
      end
   end

   // Registered read port; sees pre-write contents when reading the entry being written.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rk_out <= '0;
      end else if (rk_idx <= LAST_ROUND) begin
         rk_out <= rk_buf[rk_idx];
      end else begin
         rk_out <= '0;
      end
   end
endmodule

// File: tb/tb_aes128_key_sched_ctrl.sv
module tb_aes128_key_sched_ctrl;
   import aes_pkg::*;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       key_valid = 1'b0;
   logic       key_ready;
   rk_t        key_in = '0;
   logic [3:0] rk_idx = '0;
   rk_t        rk_out;
   logic       rk_valid;
   logic       busy;
   logic       done;

   int total = 0;
   int bad = 0;

   logic [0:2047] sbox_tab;
   logic [0:79]   rcon_tab;
   rk_t           exp_rk [0:10];

   typedef struct {
      rk_t        key;
      logic [3:0] idx;
      rk_t        exp;
   } vec_t;
   vec_t vecs [5];

   always #5 clk = ~clk;

   aes128_key_sched_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_in    (key_in),
      .rk_idx    (rk_idx),
      .rk_out    (rk_out),
      .rk_valid  (rk_valid),
      .busy      (busy),
      .done      (done)
   );

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input rk_t act, input rk_t exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %b want %b", name, act, exp);
      end
   endtask

   task automatic chk_int(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   function automatic logic [7:0] ref_sbox(input logic [7:0] b);
      return sbox_tab[int'(b)*8 +: 8];
   endfunction

   // Textbook word-wise expansion w[0..43] using the S-box table.
   task automatic ref_expand(input rk_t key);
      logic [31:0] w [0:43];
      logic [31:0] t;
      for (int i = 0; i < 4; i++) w[i] = key[i*32 +: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t = {t[23:0], t[31:24]};
            t = {ref_sbox(t[31:24]), ref_sbox(t[23:16]), ref_sbox(t[15:8]), ref_sbox(t[7:0])}
                ^ {rcon_tab[(i/4-1)*8 +: 8], 24'h0};
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r <= 10; r++) exp_rk[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic read_rk(input logic [3:0] idx, output rk_t v);
      rk_idx = idx;
      @(negedge clk);
      v = rk_out;
   endtask

   // Offer a key at a negedge, return at the negedge where done is expected (10 after acceptance).
   task automatic run_key(input rk_t key, input string name);
      int n;
      key_valid = 1'b1;
      key_in = key;
      n = 0;
      while (!key_ready && n < 30) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      key_valid = 1'b0;
      chk1($sformatf("%s busy_after_accept", name), busy, 1'b1);
      chk1($sformatf("%s rk_valid_after_accept", name), rk_valid, 1'b0);
      chk1($sformatf("%s key_ready_after_accept", name), key_ready, 1'b0);
      n = 0;
      while (!done && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk_int($sformatf("%s done_latency", name), n, 10);
      chk1($sformatf("%s rk_valid_at_done", name), rk_valid, 1'b1);
      ref_expand(key);
   endtask

   task automatic check_all(input string name);
      rk_t v;
      for (int r = 0; r <= 10; r++) begin
         read_rk(4'(r), v);
         if (r == 0) chk1($sformatf("%s done_one_cycle", name), done, 1'b0);
         chk($sformatf("%s rk%0d", name, r), v, exp_rk[r]);
      end
   endtask

   initial begin
      rk_t v, kb, kc, old1;
      int n, dcount;

      sbox_tab = {
         128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
         128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
         128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
         128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
         128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
         128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
         128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
         128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
      rcon_tab = 80'h01020408102040801b36;

      vecs[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd1,  128'ha0fafe1788542cb123a339392a6c7605};
      vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd10, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      vecs[2] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 4'd0,  128'h2b7e151628aed2a6abf7158809cf4f3c};
      vecs[3] = '{128'h0, 4'd1,  128'h62636363626363636263636362636363};
      vecs[4] = '{128'h0, 4'd10, 128'hb4ef5bcb3e92e21123e951cf6f8f188e};

      // Reset state
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk1("reset key_ready", key_ready, 1'b1);
      chk1("reset rk_valid", rk_valid, 1'b0);
      chk1("reset busy", busy, 1'b0);
      chk1("reset done", done, 1'b0);
      chk("reset rk_out", rk_out, '0);

      // Known-answer vectors
      for (int i = 0; i < 5; i++) begin
         if (i == 0 || vecs[i].key != vecs[i-1].key) run_key(vecs[i].key, $sformatf("vec%0d", i));
         read_rk(vecs[i].idx, v);
         chk($sformatf("vec%0d idx%0d", i, vecs[i].idx), v, vecs[i].exp);
      end

      // Read-before-write on entry 1, and key_valid held with another key during expansion.
      old1 = exp_rk[1];
      kb = {$urandom, $urandom, $urandom, $urandom};
      kc = ~kb;
      ref_expand(kb);
      rk_idx = 4'd1;
      key_valid = 1'b1;
      key_in = kb;
      @(negedge clk);
      key_in = kc;
      chk("rbw old_at_accept", rk_out, old1);
      @(negedge clk);
      chk("rbw old_during_write", rk_out, old1);
      @(negedge clk);
      chk("rbw new_after_write", rk_out, exp_rk[1]);
      chk1("ignored key_ready_low", key_ready, 1'b0);
      repeat (3) @(negedge clk);
      key_valid = 1'b0;
      n = 5;
      while (!done && n < 25) begin
         @(negedge clk);
         n++;
      end
      chk_int("ignored done_latency", n, 10);
      check_all("ignored");

      // Back-to-back: second key offered in the done cycle.
      run_key({$urandom, $urandom, $urandom, $urandom}, "b2b_first");
      run_key({$urandom, $urandom, $urandom, $urandom}, "b2b_second");
      check_all("b2b_second");

      // Reset in the middle of expansion (round counter at 5).
      key_valid = 1'b1;
      key_in = {$urandom, $urandom, $urandom, $urandom};
      @(negedge clk);
      key_valid = 1'b0;
      repeat (4) @(negedge clk);
      rst_n = 1'b0;
      #1;
      chk1("midrst busy", busy, 1'b0);
      chk1("midrst key_ready", key_ready, 1'b1);
      chk1("midrst rk_valid", rk_valid, 1'b0);
      chk("midrst rk_out", rk_out, '0);
      #2 rst_n = 1'b1;
      dcount = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         if (done) dcount++;
      end
      chk_int("midrst no_done", dcount, 0);
      read_rk(4'd0, v);
      chk("midrst buf0", v, '0);
      read_rk(4'd1, v);
      chk("midrst buf1", v, '0);
      read_rk(4'd4, v);
      chk("midrst buf4", v, '0);
      run_key({$urandom, $urandom, $urandom, $urandom}, "after_rst");
      check_all("after_rst");

      // Out-of-range indices and reverse sweep.
      for (int i = 11; i <= 15; i++) begin
         read_rk(4'(i), v);
         chk($sformatf("oor idx%0d", i), v, '0);
      end
      for (int i = 10; i >= 0; i--) begin
         rk_idx = 4'(i);
         @(negedge clk);
         chk($sformatf("sweep idx%0d", i), rk_out, exp_rk[i]);
      end

      // Random keys with random-index reads.
      for (int k = 0; k < 4; k++) begin
         run_key({$urandom, $urandom, $urandom, $urandom}, $sformatf("rnd%0d", k));
         for (int j = 0; j < 8; j++) begin
            n = int'($urandom_range(0, 15));
            read_rk(4'(n), v);
            chk($sformatf("rnd%0d idx%0d", k, n), v, (n <= 10) ? exp_rk[n] : '0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
